// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte producers, the shared uart_tx and
// the arbiter that multiplexes them.
//
// Signals:
//   ch0_avail/ch0_byte  channel 0 (raw receive echo) one-cycle strobe + data
//   ch1_avail/ch1_byte  channel 1 (filter output) one-cycle strobe + data
//   tx_active           uart_tx o_active
//   tx_done             uart_tx o_done, one-cycle pulse at end of frame
//   tx_avail/tx_byte    to uart_tx i_data_avail / i_data_byte
//   src                 channel of the byte most recently issued
//   overflow            sticky per-channel byte-dropped flags
//   busy                arbiter not idle
//
// Modports:
//   master  the surrounding datapath / transmitter side
//   slave   the arbiter
interface uart_tx_arbiter_if;
  logic       ch0_avail;
  logic [7:0] ch0_byte;
  logic       ch1_avail;
  logic [7:0] ch1_byte;
  logic       tx_active;
  logic       tx_done;
  logic       tx_avail;
  logic [7:0] tx_byte;
  logic       src;
  logic [1:0] overflow;
  logic       busy;

  modport master (
    output ch0_avail, ch0_byte, ch1_avail, ch1_byte, tx_active, tx_done,
    input  tx_avail, tx_byte, src, overflow, busy
  );

  modport slave (
    input  ch0_avail, ch0_byte, ch1_avail, ch1_byte, tx_active, tx_done,
    output tx_avail, tx_byte, src, overflow, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between two byte producers. Each channel owns a small
// FIFO; a round-robin scheduler issues one byte at a time and waits for the
// frame to finish before issuing the next.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  uart_tx_arbiter_if.slave (producers in, uart_tx strobe out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing in flight; grant a non-empty FIFO when tx is quiet
// ISSUE     | tx_avail strobe is out; pop the granted FIFO
// WAIT_ACT  | waiting for uart_tx to report active (or an early done)
// WAIT_DONE | frame in progress; waiting for tx_done
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE} state_t;

  state_t state, next_state;

  logic [7:0]    mem    [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   count  [2];
  logic [7:0]    push_byte [2];

  logic [1:0] push_req, push, pop, empty, full;
  logic       grant, next_grant, last_grant;

  logic       tx_avail_q, tx_avail_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       src_q, src_d;
  logic       busy_q, busy_d;
  logic [1:0] overflow_q;

  assign push_req     = {bus.ch1_avail, bus.ch0_avail};
  assign push_byte[0] = bus.ch0_byte;
  assign push_byte[1] = bus.ch1_byte;

  // A full FIFO still accepts a push on the edge it is being popped.
  always_comb begin
    pop[0] = (state == ISSUE) && !grant;
    pop[1] = (state == ISSUE) &&  grant;
    for (int c = 0; c < 2; c++) begin
      empty[c] = (count[c] == '0);
      full[c]  = (count[c] == FULL_CNT);
      push[c]  = push_req[c] && (!full[c] || pop[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= push_byte[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      overflow_q <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        if (push[c] && !pop[c])      count[c] <= count[c] + CNT_ONE;
        else if (pop[c] && !push[c]) count[c] <= count[c] - CNT_ONE;
        if (push_req[c] && !push[c]) overflow_q[c] <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      grant <= next_grant;
      if (state == ISSUE) last_grant <= grant;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_grant = grant;
    case (state)
      IDLE: begin
        // Never start a frame while the transmitter still reports active.
        if (!bus.tx_active && (!empty[0] || !empty[1])) begin
          next_state = ISSUE;
          if (!empty[0] && !empty[1]) next_grant = ~last_grant;
          else                        next_grant = empty[0];
        end
      end
      ISSUE:     next_state = WAIT_ACT;
      WAIT_ACT: begin
        // A done without a visible active cycle still ends the frame.
        if (bus.tx_done)        next_state = IDLE;
        else if (bus.tx_active) next_state = WAIT_DONE;
      end
      WAIT_DONE: if (bus.tx_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, so the strobe
  // appears in the same cycle the FSM sits in ISSUE.
  always_comb begin
    tx_avail_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    src_d      = src_q;
    busy_d     = (next_state != IDLE);
    if (state == IDLE && next_state == ISSUE) begin
      tx_avail_d = 1'b1;
      tx_byte_d  = mem[next_grant][rd_ptr[next_grant]];
    end
    if (state == ISSUE) src_d = grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_avail_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      src_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_avail_q <= tx_avail_d;
      tx_byte_q  <= tx_byte_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_avail = tx_avail_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.src      = src_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple uart_tx
// model (active one cycle after the strobe, done 20 cycles later).
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] issued_byte[$];
  logic       issued_src[$];
  logic       prev_avail   = 1'b0;
  logic       model_active = 1'b0;
  logic       hold_active  = 1'b0;
  int         model_cnt    = 0;

  assign bus.tx_active = model_active | hold_active;

  // Monitor and transmitter model, evaluated on the falling edge.
  always @(negedge clk) begin
    if (prev_avail) issued_src.push_back(bus.src);
    prev_avail = bus.tx_avail;
    if (bus.tx_avail) issued_byte.push_back(bus.tx_byte);
    bus.tx_done = 1'b0;
    if (rst) begin
      model_cnt    = 0;
      model_active = 1'b0;
    end else if (bus.tx_avail) begin
      model_cnt    = 20;
      model_active = 1'b1;
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) begin
        model_active = 1'b0;
        bus.tx_done  = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    issued_byte.delete();
    issued_src.delete();
    prev_avail = 1'b0;
  endtask

  task automatic push(input logic ch, input logic [7:0] b);
    if (ch) begin bus.ch1_avail = 1'b1; bus.ch1_byte = b; end
    else    begin bus.ch0_avail = 1'b1; bus.ch0_byte = b; end
    tick();
    bus.ch0_avail = 1'b0;
    bus.ch1_avail = 1'b0;
  endtask

  task automatic push2(input logic [7:0] b0, input logic [7:0] b1);
    bus.ch0_avail = 1'b1; bus.ch0_byte = b0;
    bus.ch1_avail = 1'b1; bus.ch1_byte = b1;
    tick();
    bus.ch0_avail = 1'b0;
    bus.ch1_avail = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (issued_byte.size() >= n && !bus.busy) break;
      tick();
    end
    if (i == budget) check({tag, "_timeout"}, issued_byte.size(), n);
  endtask

  logic [7:0] exp_tie_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       exp_tie_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int busy_cnt;
    int found;
    bus.ch0_avail = 1'b0; bus.ch0_byte = 8'h00;
    bus.ch1_avail = 1'b0; bus.ch1_byte = 8'h00;

    // Reset then idle
    do_reset(3);
    check("rst_tx_avail", bus.tx_avail, 1'b0);
    check("rst_tx_byte",  bus.tx_byte,  8'h00);
    check("rst_src",      bus.src,      1'b0);
    check("rst_overflow", bus.overflow, 2'b00);
    check("rst_busy",     bus.busy,     1'b0);
    busy_cnt = 0;
    repeat (100) begin
      tick();
      if (bus.busy || bus.tx_avail) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);

    // Single byte, with latency
    do_reset(2);
    bus.ch0_avail = 1'b1; bus.ch0_byte = 8'hA5;
    tick();                                   // after E0
    bus.ch0_avail = 1'b0;
    check("lat_e0_avail", bus.tx_avail, 1'b0);
    tick();                                   // after E1
    check("lat_e1_avail", bus.tx_avail, 1'b1);
    check("lat_e1_byte",  bus.tx_byte,  8'hA5);
    check("lat_e1_busy",  bus.busy,     1'b1);
    tick();                                   // after E2
    check("lat_e2_avail", bus.tx_avail, 1'b0);
    check("lat_e2_byte_hold", bus.tx_byte, 8'hA5);
    wait_drain("single", 1, 100);
    repeat (5) tick();
    check("single_count", issued_byte.size(), 1);
    if (issued_byte.size() >= 1) check("single_byte", issued_byte[0], 8'hA5);
    if (issued_src.size() >= 1)  check("single_src",  issued_src[0],  1'b0);
    check("single_busy_after", bus.busy, 1'b0);

    // Tie and alternation
    do_reset(2);
    push2(8'h11, 8'h22);
    repeat (6) tick();
    push2(8'h33, 8'h44);
    wait_drain("tie", 4, 400);
    repeat (5) tick();
    check("tie_count", issued_byte.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < issued_byte.size()) check($sformatf("tie_byte%0d", i), issued_byte[i], exp_tie_b[i]);
      if (i < issued_src.size())  check($sformatf("tie_src%0d", i),  issued_src[i],  exp_tie_s[i]);
    end

    // Overflow while the transmitter is held active
    do_reset(2);
    hold_active = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) push(1'b1, 8'(i));
    repeat (4) tick();
    check("ovf_flag", bus.overflow, 2'b10);
    check("ovf_no_issue_while_active", issued_byte.size(), 0);
    hold_active = 1'b0;
    wait_drain("ovf", 4, 400);
    repeat (30) tick();
    check("ovf_count", issued_byte.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < issued_byte.size()) check($sformatf("ovf_byte%0d", i), issued_byte[i], 8'(i + 1));
    check("ovf_sticky", bus.overflow, 2'b10);

    // Full FIFO, push on the ISSUE cycle
    do_reset(2);
    hold_active = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(1'b0, 8'h50 + 8'(i));
    check("full_no_ovf_yet", bus.overflow, 2'b00);
    hold_active = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_avail) begin found = 1; break; end
    end
    check("full_first_issue_seen", found, 1);
    push(1'b0, 8'h54);                        // sampled on the ISSUE edge
    wait_drain("full", 5, 600);
    repeat (30) tick();
    check("full_overflow", bus.overflow, 2'b00);
    check("full_count", issued_byte.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < issued_byte.size()) check($sformatf("full_byte%0d", i), issued_byte[i], 8'h50 + 8'(i));

    // Reset mid-frame
    do_reset(2);
    push(1'b0, 8'h61);
    repeat (6) tick();
    push(1'b0, 8'h62);
    push(1'b0, 8'h63);
    check("midrst_busy_before", bus.busy, 1'b1);
    do_reset(2);
    check("midrst_busy_after",  bus.busy,     1'b0);
    check("midrst_avail_after", bus.tx_avail, 1'b0);
    repeat (60) tick();
    check("midrst_no_issue", issued_byte.size(), 0);
    push(1'b0, 8'h64);
    wait_drain("midrst", 1, 100);
    repeat (30) tick();
    check("midrst_new_count", issued_byte.size(), 1);
    if (issued_byte.size() >= 1) check("midrst_new_byte", issued_byte[0], 8'h64);
    check("midrst_overflow", bus.overflow, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte producers: channel 0 (raw receive echo) and channel 1 (filter output). Each channel has its own small FIFO that absorbs bytes arriving while the transmitter is busy. A round-robin scheduler issues one byte at a time to uart_tx and waits for that frame to complete before issuing the next. The block sits between the receive/filter datapath and uart_tx in the top level.

## Interface
- FIFO_DEPTH, 4: entries per channel FIFO; must be a power of 2, at least 2.
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- i_ch0_avail  in  1  one-cycle strobe; i_ch0_byte is valid for channel 0.
- i_ch0_byte  in  8  channel 0 data.
- i_ch1_avail  in  1  one-cycle strobe; i_ch1_byte is valid for channel 1.
- i_ch1_byte  in  8  channel 1 data.
- i_tx_active  in  1  from uart_tx o_active.
- i_tx_done  in  1  from uart_tx o_done (one-cycle pulse at end of frame).
- o_tx_avail  out  1  to uart_tx i_data_avail; one-cycle strobe.
- o_tx_byte  out  8  to uart_tx i_data_byte.
- o_src  out  1  channel of the byte most recently issued.
- o_overflow  out  2  sticky per-channel flag: a byte was dropped because its FIFO was full.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- FIFOs: one per channel, each FIFO_DEPTH deep.
  - A strobe with the FIFO not full writes the byte.
  - A strobe with the FIFO full drops the byte and sets o_overflow[ch].
  - A push and a pop on the same edge, with the FIFO full, are both accepted. Count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- State machine:
  - IDLE:
    - If exactly one FIFO is non-empty, grant that channel.
    - If both are non-empty, grant the channel not equal to last_grant.
    - On a grant, go to ISSUE.
  - ISSUE:
    - o_tx_avail=1 and o_tx_byte=head of the granted FIFO.
    - Pop that FIFO, set last_grant and o_src to the granted channel.
    - Go to WAIT_ACT.
  - WAIT_ACT: stay until i_tx_active=1, then go to WAIT_DONE.
    - If i_tx_done=1 arrives here, go directly to IDLE. This covers a transmitter that reports done without a visible active cycle.
  - WAIT_DONE: stay until i_tx_done=1, then go to IDLE.
- The state machine never issues a byte while i_tx_active=1.
- Reset:
  - Clears both FIFOs, o_overflow, last_grant (=1, so channel 0 wins first tie) and state (IDLE).
  - A reset mid-frame abandons the frame. Bytes held in FIFOs are lost.
- o_overflow clears only on reset.

## Timing
- Reset values:
  - o_tx_avail=0, o_tx_byte=8'h00, o_src=0, o_overflow=2'b00, o_busy=0.
  - FIFO counts 0, state IDLE.
- All outputs are registered.
- Latency with the block idle:
  - Strobe sampled at edge E0.
  - Grant decided at E1, so ISSUE is entered and o_tx_avail=1 is visible after E1.
  - o_tx_avail falls after E2.
  - Total: 1 cycle from the push edge to the strobe.
- o_tx_byte holds its last value when o_tx_avail=0.
- Between frames: minimum one IDLE cycle after i_tx_done before the next ISSUE.
- o_busy=1 from ISSUE through the cycle i_tx_done is sampled.

## Test plan
- Reset then idle:
  - Stimulus: assert reset for 3 cycles, no strobes.
  - Response: all outputs at reset values, o_busy=0 for 100 cycles.
- Single byte:
  - Stimulus: ch0 strobe with 8'hA5. Uart_tx model raises active 1 cycle later and pulses done 20 cycles later.
  - Response: exactly one o_tx_avail pulse with o_tx_byte=8'hA5 and o_src=0. o_busy falls after done.
- Tie and alternation:
  - Stimulus: same-cycle strobes ch0=8'h11 and ch1=8'h22, then ch0=8'h33 and ch1=8'h44 while the first frame is in progress.
  - Response: issue order is 11(src0), 22(src1), 33(src0), 44(src1).
- Overflow:
  - Stimulus: 5 ch1 strobes with values 1..5 while the transmitter is held active. FIFO_DEPTH=4.
  - Response: o_overflow=2'b10. Bytes 1,2,3,4 are issued in order. Byte 5 is never issued.
- Full FIFO, simultaneous push and pop:
  - Stimulus: ch0 FIFO full; a ch0 strobe lands on the ISSUE cycle.
  - Response: the strobed byte is accepted, o_overflow[0] stays 0, and all 5 bytes are eventually sent.
- Reset mid-frame:
  - Stimulus: assert reset while in WAIT_DONE with 2 bytes queued.
  - Response: state IDLE and FIFOs empty; no o_tx_avail pulse after reset until a new strobe arrives.
